// File: rtl/adbg_burst_crc_rx_pkg.sv
// adbg_burst_crc_rx_pkg: shared state encoding and CRC constants for the burst CRC receiver.
package adbg_burst_crc_rx_pkg;
    localparam int CRC_WIDTH = 32;
    localparam logic [CRC_WIDTH-1:0] CRC_INIT = 32'hFFFF_FFFF;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/adbg_burst_crc_rx_if.sv
// adbg_burst_crc_rx_if: host/TAP-side control, serial bit stream, CRC engine hookup and results.
// master: drives start/burst_len/abort/bit_valid/bit_in/crc_serial_in; slave: the receiver.
interface adbg_burst_crc_rx_if
    import adbg_burst_crc_rx_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  abort;
    logic                  bit_valid;
    logic                  bit_in;
    logic                  crc_data;
    logic                  crc_enable;
    logic                  crc_shift;
    logic                  crc_clr;
    logic                  crc_serial_in;
    logic [WORD_WIDTH-1:0] word_out;
    logic                  word_valid;
    logic                  busy;
    logic                  done;
    logic                  crc_ok;
    logic [CRC_WIDTH-1:0]  rx_crc;

    modport master (
        output start, burst_len, abort, bit_valid, bit_in, crc_serial_in,
        input  crc_data, crc_enable, crc_shift, crc_clr, word_out, word_valid, busy, done, crc_ok, rx_crc
    );
    modport slave (
        input  start, burst_len, abort, bit_valid, bit_in, crc_serial_in,
        output crc_data, crc_enable, crc_shift, crc_clr, word_out, word_valid, busy, done, crc_ok, rx_crc
    );
endinterface

// File: rtl/adbg_bit_deser.sv
// adbg_bit_deser: LSB-first serial-to-parallel word builder with bit counter.
// clk/rst: clock, sync active-high reset; clr: restart bit counter; en/bit_in: valid serial bit;
// word_out/word_valid: completed word and its one-cycle pulse; last_bit: counter sits on the final bit.
module adbg_bit_deser #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  bit_in,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    output logic                  last_bit
);
    localparam int CW = $clog2(WORD_WIDTH);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] sr_q, sr_d, word_q, word_d;
    logic                  vld_q, vld_d;

    // New bits enter at the MSB so the first bit of a word ends up at bit 0.
    always_comb begin
        last_bit = cnt_q == CW'(WORD_WIDTH - 1);
        sr_d     = en ? {bit_in, sr_q[WORD_WIDTH-1:1]} : sr_q;
        cnt_d    = clr ? '0 : en ? (last_bit ? '0 : cnt_q + CW'(1)) : cnt_q;
        vld_d    = en && last_bit;
        word_d   = vld_d ? sr_d : word_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sr_q   <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            word_q <= word_d;
            vld_q  <= vld_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = vld_q;
endmodule

// File: rtl/adbg_burst_crc_rx.sv
// adbg_burst_crc_rx: burst-write serial receiver that feeds the debug CRC32 engine and checks the trailer.
// clk/rst: clock, sync active-high reset; bus (slave): start/burst_len/abort control, bit_valid/bit_in
// stream, crc_data/enable/shift/clr to the engine, crc_serial_in back, word_out/word_valid, busy, done,
// crc_ok, rx_crc. Define ADBG_BURST_CRC_CAPTURE_EN to capture the received trailer into rx_crc.
module adbg_burst_crc_rx
    import adbg_burst_crc_rx_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    adbg_burst_crc_rx_if.slave  bus
);
    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [4:0]            chk_q, chk_d;
    logic                  mis_q, mis_d, ok_q, ok_d;
    logic                  in_idle, in_clr, in_data, in_check, start_hit;
    logic                  deser_en, bit_last, word_end, chk_bit, chk_end, bit_mis;
    logic [WORD_WIDTH-1:0] deser_word;
    logic                  deser_valid;
    logic [CRC_WIDTH-1:0]  rx_crc;

    assign in_idle   = state_q == ST_IDLE;
    assign in_clr    = state_q == ST_CLR;
    assign in_data   = state_q == ST_DATA;
    assign in_check  = state_q == ST_CHECK;
    assign start_hit = in_idle && bus.start;
    assign deser_en  = in_data && bus.bit_valid;
    assign word_end  = deser_en && bit_last;
    assign chk_bit   = in_check && bus.bit_valid;
    assign chk_end   = chk_bit && chk_q == 5'd31;
    assign bit_mis   = bus.bit_in ^ bus.crc_serial_in;

    adbg_bit_deser #(.WORD_WIDTH(WORD_WIDTH)) u_deser (
        .clk        (clk),
        .rst        (rst),
        .clr        (in_clr),
        .en         (deser_en),
        .bit_in     (bus.bit_in),
        .word_out   (deser_word),
        .word_valid (deser_valid),
        .last_bit   (bit_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            chk_q   <= '0;
            mis_q   <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            mis_q   <= mis_d;
            ok_q    <= ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = bus.start ? ST_CLR : ST_IDLE;
            ST_CLR:   state_d = bus.abort ? ST_IDLE : (len_q != '0 ? ST_DATA : ST_CHECK);
            ST_DATA:  state_d = bus.abort ? ST_IDLE : (word_end && len_q == LEN_WIDTH'(1)) ? ST_CHECK : ST_DATA;
            ST_CHECK: state_d = bus.abort ? ST_IDLE : chk_end ? ST_DONE : ST_CHECK;
            default:  state_d = ST_IDLE;
        endcase
    end

    // crc_ok is resolved on entry to DONE (including the 32nd bit) so it is valid alongside done.
    always_comb begin
        len_d = start_hit ? bus.burst_len : word_end ? len_q - LEN_WIDTH'(1) : len_q;
        chk_d = start_hit ? '0 : chk_bit ? chk_q + 5'd1 : chk_q;
        mis_d = start_hit ? 1'b0 : chk_bit ? (mis_q | bit_mis) : mis_q;
        ok_d  = start_hit ? 1'b0 : (chk_end && !bus.abort) ? !(mis_q | bit_mis) : ok_q;
    end

`ifdef ADBG_BURST_CRC_CAPTURE_EN
    logic [CRC_WIDTH-1:0] rx_q, rx_d;
    always_comb rx_d = start_hit ? '0 : chk_bit ? {bus.bit_in, rx_q[CRC_WIDTH-1:1]} : rx_q;
    always_ff @(posedge clk) rx_q <= rst ? '0 : rx_d;
    assign rx_crc = rx_q;
`else
    assign rx_crc = '0;
`endif

    always_comb begin
        bus.busy       = !in_idle;
        bus.done       = state_q == ST_DONE;
        bus.crc_clr    = in_clr;
        bus.crc_data   = in_data && bus.bit_in;
        bus.crc_enable = deser_en;
        bus.crc_shift  = chk_bit;
        bus.word_out   = deser_word;
        bus.word_valid = deser_valid;
        bus.crc_ok     = ok_q;
        bus.rx_crc     = rx_crc;
    end
endmodule

// File: tb/tb_adbg_burst_crc_rx.sv
// tb_adbg_burst_crc_rx: directed and randomized bursts against a CRC32 reference, with an engine model.
module tb_adbg_burst_crc_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adbg_burst_crc_rx_if #(.WORD_WIDTH(8), .LEN_WIDTH(16)) bus();
    adbg_burst_crc_rx #(.WORD_WIDTH(8), .LEN_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Debug CRC32 engine stand-in: reflected polynomial, preset on clr, plain right shift on shift.
    logic [31:0] eng = 32'hFFFF_FFFF;
    always @(posedge clk)
        eng <= bus.crc_clr ? 32'hFFFF_FFFF :
               bus.crc_enable ? ((eng[0] ^ bus.crc_data) ? (eng >> 1) ^ 32'hEDB8_8320 : eng >> 1) :
               bus.crc_shift ? eng >> 1 : eng;
    assign bus.crc_serial_in = eng[0];

    int n_en = 0, n_sh = 0, n_done = 0, n_viol = 0;
    byte unsigned wq[$];
    always @(posedge clk) begin
        if (bus.crc_enable) n_en++;
        if (bus.crc_shift) n_sh++;
        if (bus.done) n_done++;
        if ((bus.crc_enable && bus.crc_shift) || (bus.crc_clr && (bus.crc_enable || bus.crc_shift))) n_viol++;
        if (bus.word_valid) wq.push_back(bus.word_out);
    end

    int checks = 0, errors = 0;
    byte unsigned pay[$];

`ifdef ADBG_BURST_CRC_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Standard reflected CRC32 of the payload, preset all-ones, no final inversion.
    function automatic logic [31:0] ref_crc(input byte unsigned p[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (p[k])
            for (int i = 0; i < 8; i++)
                c = (c[0] ^ p[k][i]) ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
        return c;
    endfunction

    task automatic send_bit(input logic b, input int gmax);
        repeat ($urandom_range(gmax, 0)) @(negedge clk);
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        @(negedge clk);
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
    endtask

    task automatic begin_burst(input int len);
        bus.start     = 1'b1;
        bus.burst_len = 16'(len);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic burst(input string tag, input logic [31:0] trl, input int gmax, input bit poke);
        int b_en, b_sh, b_dn, b_w, nw;
        logic [31:0] good;
        b_en = n_en; b_sh = n_sh; b_dn = n_done; b_w = wq.size();
        good = ref_crc(pay);
        begin_burst(pay.size());
        check({tag, " clr"}, 32'(bus.crc_clr), 1);
        check({tag, " busy"}, 32'(bus.busy), 1);
        @(negedge clk);
        foreach (pay[k]) begin
            for (int i = 0; i < 8; i++) send_bit(pay[k][i], gmax);
            if (poke && k == 0) begin
                bus.start = 1'b1; bus.burst_len = 16'd5;
                @(negedge clk);
                bus.start = 1'b0;
            end
        end
        for (int i = 0; i < 32; i++) send_bit(trl[i], gmax);
        check({tag, " done"}, 32'(bus.done), 1);
        @(negedge clk);
        check({tag, " done_cleared"}, 32'(bus.done), 0);
        check({tag, " idle"}, 32'(bus.busy), 0);
        check({tag, " crc_ok"}, 32'(bus.crc_ok), 32'(trl == good));
        nw = wq.size() - b_w;
        check({tag, " words"}, nw, pay.size());
        for (int k = 0; k < nw && k < pay.size(); k++)
            check($sformatf("%s word%0d", tag, k), 32'(wq[b_w + k]), 32'(pay[k]));
        check({tag, " enables"}, n_en - b_en, 8 * pay.size());
        check({tag, " shifts"}, n_sh - b_sh, 32);
        check({tag, " done_pulses"}, n_done - b_dn, 1);
        check({tag, " rx_crc"}, bus.rx_crc, CAP ? trl : 32'h0);
    endtask

    initial begin
        int b_w, b_dn, n;
        logic [31:0] t;
        bus.start = 0; bus.burst_len = 0; bus.abort = 0; bus.bit_valid = 0; bus.bit_in = 0;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(bus.busy), 0);
        check("rst done", 32'(bus.done), 0);
        check("rst word_out", 32'(bus.word_out), 0);
        check("rst word_valid", 32'(bus.word_valid), 0);
        check("rst crc_ok", 32'(bus.crc_ok), 0);
        check("rst rx_crc", bus.rx_crc, 0);
        check("rst crc_ctl", {bus.crc_clr, bus.crc_enable, bus.crc_shift, bus.crc_data}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) pay.push_back(8'(8'h31 + i));
        burst("ascii_good", 32'h340B_C6D9, 0, 0);
        burst("ascii_bad", 32'h340B_C659, 0, 0);
        burst("ascii_gapped", 32'h340B_C6D9, 5, 0);

        pay.delete();
        burst("len0", 32'hFFFF_FFFF, 0, 0);

        for (int r = 0; r < 4; r++) begin
            pay.delete();
            n = $urandom_range(5, 1);
            for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
            t = ref_crc(pay);
            if ($urandom_range(1, 0) == 1) t[$urandom_range(31, 0)] ^= 1'b1;
            burst($sformatf("rand%0d", r), t, 2, 0);
        end

        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back(8'($urandom));
        b_w = wq.size(); b_dn = n_done;
        begin_burst(3);
        @(negedge clk);
        for (int i = 0; i < 20; i++) send_bit(pay[i / 8][i % 8], 0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort busy", 32'(bus.busy), 0);
        repeat (3) @(negedge clk);
        check("abort words", wq.size() - b_w, 2);
        check("abort no_done", n_done - b_dn, 0);
        check("abort crc_ok", 32'(bus.crc_ok), 0);
        burst("post_abort", ref_crc(pay), 0, 0);

        pay.delete();
        pay.push_back(8'h5A);
        t = ref_crc(pay);
        begin_burst(1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) send_bit(pay[0][i], 0);
        for (int i = 0; i < 10; i++) send_bit(t[i], 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", 32'(bus.busy), 0);
        check("midrst word_out", 32'(bus.word_out), 0);
        check("midrst crc_ok", 32'(bus.crc_ok), 0);
        check("midrst rx_crc", bus.rx_crc, 0);
        check("midrst done", 32'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);

        pay.delete();
        pay.push_back(8'hC3);
        pay.push_back(8'h7E);
        burst("start_ignored", ref_crc(pay), 1, 1);

        check("ctl_exclusive", n_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
